// File: rtl/vga_sync_receiver_if.sv
// VGA sink bus: raw sync/blank inputs plus the recovered coordinates and timing status.
// pixel_valid qualifies x/y in the same cycle; there is no back-pressure, and every other output is a level or a one-cycle pulse.
interface vga_sync_receiver_if;
  logic       hsync_in;
  logic       vsync_in;
  logic       blank_n_in;
  logic [9:0] x;
  logic [9:0] y;
  logic       pixel_valid;
  logic       line_start;
  logic       frame_start;
  logic [9:0] line_len;
  logic [9:0] frame_lines;
  logic       locked;
  logic       timing_error;
  logic [1:0] dbg_state;

  modport master (
    output hsync_in, vsync_in, blank_n_in,
    input  x, y, pixel_valid, line_start, frame_start,
    input  line_len, frame_lines, locked, timing_error, dbg_state
  );

  modport slave (
    input  hsync_in, vsync_in, blank_n_in,
    output x, y, pixel_valid, line_start, frame_start,
    output line_len, frame_lines, locked, timing_error, dbg_state
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers active-pixel coordinates, measures line/frame
// lengths and tracks lock against the nominal mode.
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input logic                pixel_clk,
  input logic                reset_n,
  vga_sync_receiver_if.slave vga
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [9:0] CNT_MAX    = 10'd1023;
  localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [2:0] LOCK_C     = 3'(LOCK_FRAMES);
  localparam logic       SYNC_LVL   = (SYNC_POL != 0);

  logic       hs_q, vs_q, bn_q, hs_prev_q, vs_prev_q;
  logic [9:0] hcnt_q, hcnt_d, xcnt_q, xcnt_d, ycnt_q, ycnt_d, vcnt_q, vcnt_d;
  logic       h_started_q, h_started_d, frame_err_q, frame_err_d;
  logic [2:0] good_q, good_d;
  logic [1:0] state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic       pv_q, pv_d, ls_q, ls_d, fs_q, fs_d, locked_q, locked_d, terr_q, terr_d;

  logic       h_edge, v_edge, line_active, line_bad, frame_cnt_bad, frame_bad;
  logic [9:0] line_len_new, xcnt_cur, ycnt_after, vcnt_after;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  assign h_edge = (hs_q == SYNC_LVL) && (hs_prev_q != SYNC_LVL);
  assign v_edge = (vs_q == SYNC_LVL) && (vs_prev_q != SYNC_LVL);

  always_comb begin
    hcnt_d        = hcnt_q;
    xcnt_d        = xcnt_q;
    ycnt_d        = ycnt_q;
    vcnt_d        = vcnt_q;
    h_started_d   = h_started_q;
    frame_err_d   = frame_err_q;
    good_d        = good_q;
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    locked_d      = locked_q;
    pv_d          = bn_q;
    ls_d          = h_edge;
    fs_d          = v_edge;
    terr_d        = 1'b0;

    // A line closing before the first measured edge counts as bad timing.
    line_len_new  = sat_inc(hcnt_q);
    line_active   = (xcnt_q != 10'd0);
    line_bad      = !h_started_q || (line_len_new != H_TOTAL_C) ||
                    (line_active && (xcnt_q != H_ACTIVE_C));
    ycnt_after    = (h_edge && line_active) ? sat_inc(ycnt_q) : ycnt_q;
    vcnt_after    = h_edge ? sat_inc(vcnt_q) : vcnt_q;
    frame_cnt_bad = (vcnt_after != V_TOTAL_C) || (ycnt_after != V_ACTIVE_C);
    frame_bad     = frame_err_q || (h_edge && line_bad) || frame_cnt_bad;

    if (h_edge) begin
      hcnt_d      = 10'd0;
      h_started_d = 1'b1;
      vcnt_d      = vcnt_after;
      ycnt_d      = ycnt_after;
      if (h_started_q) line_len_d = line_len_new;
      if (line_bad) frame_err_d = 1'b1;
    end else begin
      hcnt_d = sat_inc(hcnt_q);
    end

    xcnt_cur = h_edge ? 10'd0 : xcnt_q;
    xcnt_d   = xcnt_cur;
    if (bn_q) begin
      x_d    = xcnt_cur;
      xcnt_d = sat_inc(xcnt_cur);
      y_d    = v_edge ? 10'd0 : ycnt_after;
    end else if (v_edge) begin
      y_d = 10'd0;
    end

    // The line close above is folded in before the frame is closed here.
    if (v_edge) begin
      frame_lines_d = vcnt_after;
      vcnt_d        = 10'd0;
      ycnt_d        = 10'd0;
      frame_err_d   = 1'b0;
    end

    case (state_q)
      ST_SEARCH: begin
        locked_d = 1'b0;
        if (v_edge) begin
          state_d = ST_CHECK;
          good_d  = 3'd0;
        end
      end
      ST_CHECK: begin
        if (v_edge) begin
          if (frame_bad) begin
            good_d = 3'd0;
          end else if (good_q + 3'd1 == LOCK_C) begin
            good_d   = good_q + 3'd1;
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end else begin
            good_d = good_q + 3'd1;
          end
        end
      end
      ST_LOCKED: begin
        if ((h_edge && line_bad) || (v_edge && frame_cnt_bad)) begin
          terr_d   = 1'b1;
          locked_d = 1'b0;
          state_d  = ST_SEARCH;
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        locked_d = 1'b0;
      end
    endcase

    if ((state_d == ST_SEARCH) && (state_q != ST_SEARCH)) begin
      frame_err_d = 1'b0;
      h_started_d = 1'b0;
      good_d      = 3'd0;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      bn_q          <= 1'b0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      hcnt_q        <= 10'd0;
      xcnt_q        <= 10'd0;
      ycnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      h_started_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      good_q        <= 3'd0;
      state_q       <= ST_SEARCH;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      line_len_q    <= 10'd0;
      frame_lines_q <= 10'd0;
      pv_q          <= 1'b0;
      ls_q          <= 1'b0;
      fs_q          <= 1'b0;
      locked_q      <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      hs_q          <= vga.hsync_in;
      vs_q          <= vga.vsync_in;
      bn_q          <= vga.blank_n_in;
      hs_prev_q     <= hs_q;
      vs_prev_q     <= vs_q;
      hcnt_q        <= hcnt_d;
      xcnt_q        <= xcnt_d;
      ycnt_q        <= ycnt_d;
      vcnt_q        <= vcnt_d;
      h_started_q   <= h_started_d;
      frame_err_q   <= frame_err_d;
      good_q        <= good_d;
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      pv_q          <= pv_d;
      ls_q          <= ls_d;
      fs_q          <= fs_d;
      locked_q      <= locked_d;
      terr_q        <= terr_d;
    end
  end

  assign vga.x            = x_q;
  assign vga.y            = y_q;
  assign vga.pixel_valid  = pv_q;
  assign vga.line_start   = ls_q;
  assign vga.frame_start  = fs_q;
  assign vga.line_len     = line_len_q;
  assign vga.frame_lines  = frame_lines_q;
  assign vga.locked       = locked_q;
  assign vga.timing_error = terr_q;
  assign vga.dbg_state    = state_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled 16x6 mode (24 clocks/line, 10 lines/frame).
// u_dut1 sees active-low syncs; u_dut2 sees active-high syncs with vsync and hsync edges coincident.
module tb_vga_sync_receiver;

  localparam int HA = 16, HT = 24, HS_START = 18, HS_END = 22;
  localparam int VA = 6,  VT = 10, VS_START = 7,  VS_END = 9;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   tag_d1 = 0, tag_d2 = 0;
  int   te1_cnt = 0, fs1_cnt = 0, both2_cnt = 0, te_base = 0;
  logic [9:0] te1_line_len = '0, te1_frame_lines = '0;
  logic       te1_locked = 1'b0;

  vga_sync_receiver_if v1 ();
  vga_sync_receiver_if v2 ();

  vga_sync_receiver #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
                      .SYNC_POL(0), .LOCK_FRAMES(2))
    u_dut1 (.pixel_clk(clk), .reset_n(rst_n), .vga(v1.slave));

  vga_sync_receiver #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
                      .SYNC_POL(1), .LOCK_FRAMES(2))
    u_dut2 (.pixel_clk(clk), .reset_n(rst_n), .vga(v2.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // event monitor
  always @(negedge clk) begin
    if (v1.timing_error) begin
      te1_cnt++;
      te1_line_len    = v1.line_len;
      te1_frame_lines = v1.frame_lines;
      te1_locked      = v1.locked;
    end
    if (v1.frame_start) fs1_cnt++;
    if (v2.line_start && v2.frame_start) both2_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pixel(input int tag);
    int ex, ey;
    ex = (tag == 1) ? 0 : (tag == 2) ? HA - 1 : 7;
    ey = (tag == 1) ? 0 : (tag == 2) ? VA - 1 : 3;
    check_eq($sformatf("pv1_t%0d", tag), 32'(v1.pixel_valid), 32'd1);
    check_eq($sformatf("x1_t%0d", tag), 32'(v1.x), 32'(ex));
    check_eq($sformatf("y1_t%0d", tag), 32'(v1.y), 32'(ey));
    check_eq($sformatf("x2_t%0d", tag), 32'(v2.x), 32'(ex));
    check_eq($sformatf("y2_t%0d", tag), 32'(v2.y), 32'(ey));
  endtask

  // driver tasks: inputs change on the falling edge; outputs seen now came from the drive two falls ago
  task automatic drive(input logic hs, input logic vs, input logic vs_al, input logic bn, input int tag);
    @(negedge clk);
    if (tag_d2 != 0) check_pixel(tag_d2);
    tag_d2 = tag_d1;
    tag_d1 = tag;
    v1.hsync_in   = hs;
    v1.vsync_in   = vs;
    v1.blank_n_in = bn;
    v2.hsync_in   = ~hs;
    v2.vsync_in   = ~vs_al;
    v2.blank_n_in = bn;
  endtask

  task automatic drive_pix(input int ln, input int h, input bit tag_en);
    logic hs, vs, vs_al, bn;
    int   tag;
    hs    = !(h >= HS_START && h < HS_END);
    vs    = !(ln >= VS_START && ln < VS_END);
    vs_al = !((ln == VS_START && h >= HS_START) || (ln == VS_START + 1) ||
              (ln == VS_END && h < HS_START));
    bn    = (h < HA) && (ln < VA);
    tag   = 0;
    if (tag_en) begin
      if (ln == 0 && h == 0)                tag = 1;
      else if (ln == VA - 1 && h == HA - 1) tag = 2;
      else if (ln == 3 && h == 7)           tag = 3;
    end
    drive(hs, vs, vs_al, bn, tag);
  endtask

  task automatic gen_frame(input int first_line, input int n_lines, input int short_line, input bit tag_en);
    for (int ln = first_line; ln < n_lines; ln++) begin
      for (int h = 0; h < ((ln == short_line) ? HT - 1 : HT); h++) begin
        drive_pix(ln, h, tag_en);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v1.hsync_in = 1'b1; v1.vsync_in = 1'b1; v1.blank_n_in = 1'b0;
    v2.hsync_in = 1'b0; v2.vsync_in = 1'b0; v2.blank_n_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pv",    32'(v1.pixel_valid),  32'd0);
    check_eq("rst_x",     32'(v1.x),            32'd0);
    check_eq("rst_y",     32'(v1.y),            32'd0);
    check_eq("rst_ls",    32'(v1.line_start),   32'd0);
    check_eq("rst_fs",    32'(v1.frame_start),  32'd0);
    check_eq("rst_len",   32'(v1.line_len),     32'd0);
    check_eq("rst_lines", 32'(v1.frame_lines),  32'd0);
    check_eq("rst_lock",  32'(v1.locked),       32'd0);
    check_eq("rst_terr",  32'(v1.timing_error), 32'd0);
    rst_n = 1'b1;

    // nominal timing: lock at third vsync edge
    gen_frame(0, VT, -1, 1'b0);
    gen_frame(0, VT, -1, 1'b0);
    check_eq("lock_f2", 32'(v1.locked), 32'd0);
    gen_frame(0, VT, -1, 1'b1);
    check_eq("lock_f3",     32'(v1.locked),      32'd1);
    check_eq("len_f3",      32'(v1.line_len),    32'(HT));
    check_eq("lines_f3",    32'(v1.frame_lines), 32'(VT));
    check_eq("fs_cnt_f3",   32'(fs1_cnt),        32'd3);
    check_eq("lock2_f3",    32'(v2.locked),      32'd1);
    check_eq("len2_f3",     32'(v2.line_len),    32'(HT));
    check_eq("lines2_f3",   32'(v2.frame_lines), 32'(VT));
    check_eq("both2_cnt",   32'(both2_cnt),      32'd3);

    // one short line while locked
    te_base = te1_cnt;
    gen_frame(0, VT, 2, 1'b0);
    check_eq("short_te_cnt", 32'(te1_cnt - te_base), 32'd1);
    check_eq("short_len",    32'(te1_line_len),      32'(HT - 1));
    check_eq("short_lockte", 32'(te1_locked),        32'd0);
    check_eq("short_lock",   32'(v1.locked),         32'd0);
    gen_frame(0, VT, -1, 1'b0);
    check_eq("relock_f5", 32'(v1.locked), 32'd0);
    gen_frame(0, VT, -1, 1'b0);
    check_eq("relock_f6", 32'(v1.locked), 32'd1);

    // frame one line short
    gen_frame(0, VT - 1, -1, 1'b0);
    check_eq("f7_lock", 32'(v1.locked), 32'd1);
    te_base = te1_cnt;
    gen_frame(0, VT, -1, 1'b0);
    check_eq("sframe_te_cnt", 32'(te1_cnt - te_base), 32'd1);
    check_eq("sframe_te_lines", 32'(te1_frame_lines), 32'(VT - 1));
    check_eq("sframe_lines",  32'(v1.frame_lines),    32'(VT - 1));
    check_eq("sframe_lock",   32'(v1.locked),         32'd0);
    gen_frame(0, VT, -1, 1'b0);
    gen_frame(0, VT, -1, 1'b0);
    check_eq("relock_f10", 32'(v1.locked), 32'd0);
    gen_frame(0, VT, -1, 1'b0);
    check_eq("relock_f11", 32'(v1.locked), 32'd1);

    // hsync stuck for 2000 clocks
    te_base = te1_cnt;
    repeat (2000) drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check_eq("stuck_hold_lock", 32'(v1.locked), 32'd1);
    gen_frame(0, VT, -1, 1'b0);
    check_eq("stuck_te_cnt", 32'(te1_cnt - te_base), 32'd1);
    check_eq("stuck_len",    32'(te1_line_len),      32'd1023);
    check_eq("stuck_lock",   32'(v1.locked),         32'd0);
    gen_frame(0, VT, -1, 1'b0);
    check_eq("stuck_nolock", 32'(v1.locked), 32'd0);
    gen_frame(0, VT, -1, 1'b0);
    check_eq("stuck_relock", 32'(v1.locked), 32'd1);

    // asynchronous reset mid-line at y=2
    gen_frame(0, 2, -1, 1'b0);
    for (int h = 0; h <= 8; h++) drive_pix(2, h, 1'b0);
    check_eq("pre_rst_pv",   32'(v1.pixel_valid), 32'd1);
    check_eq("pre_rst_x",    32'(v1.x),           32'd6);
    check_eq("pre_rst_y",    32'(v1.y),           32'd2);
    check_eq("pre_rst_lock", 32'(v1.locked),      32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_pv",    32'(v1.pixel_valid), 32'd0);
    check_eq("arst_x",     32'(v1.x),           32'd0);
    check_eq("arst_y",     32'(v1.y),           32'd0);
    check_eq("arst_len",   32'(v1.line_len),    32'd0);
    check_eq("arst_lines", 32'(v1.frame_lines), 32'd0);
    check_eq("arst_lock",  32'(v1.locked),      32'd0);
    check_eq("arst_lock2", 32'(v2.locked),      32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int h = 9; h < HT; h++) drive_pix(2, h, 1'b0);
    gen_frame(3, VT, -1, 1'b0);
    check_eq("post_rst_e1", 32'(v1.locked), 32'd0);
    gen_frame(0, VT, -1, 1'b0);
    check_eq("post_rst_e2", 32'(v1.locked), 32'd0);
    gen_frame(0, VT, -1, 1'b0);
    check_eq("post_rst_e3",  32'(v1.locked), 32'd1);
    check_eq("post_rst_e3b", 32'(v2.locked), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
Sink-side counterpart of the VGA timing generator. It samples hsync/vsync/blank_n on the pixel clock, recovers the active-pixel coordinates, and measures line and frame lengths. A lock state machine checks the measured timing against the nominal mode. It serves as an in-system timing checker on the VGA bus and as the front end for frame capture and loopback test.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
H_TOTAL, 800, pixel clocks per line (hsync leading edge to next leading edge)
V_TOTAL, 525, lines per frame (vsync leading edge to next leading edge)
SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)
LOCK_FRAMES, 2, consecutive good frames required to lock (1..7)

Ports:
pixel_clk  input  1  pixel clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
hsync_in  input  1  horizontal sync
vsync_in  input  1  vertical sync
blank_n_in  input  1  high during active video
x  output  10  active-pixel column, 0-based
y  output  10  active-line row, 0-based
pixel_valid  output  1  x/y identify a valid active pixel
line_start  output  1  one-cycle pulse on hsync leading edge
frame_start  output  1  one-cycle pulse on vsync leading edge
line_len  output  10  last measured line length in clocks
frame_lines  output  10  last measured frame length in lines
locked  output  1  timing matches parameters
timing_error  output  1  one-cycle pulse when lock is lost

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0. Counters and the input stage are cleared. FSM goes to SEARCH.
- Input stage: the three inputs are registered once. The previous sampled value is kept for edge detection.
- Leading edge: the sampled sync changes from not-asserted to the SYNC_POL level.
- Latency:
  - A sample captured at edge E drives pixel_valid, x, y, line_start and frame_start at edge E+1.
  - The same sample drives the line_len and frame_lines updates at edge E+1.
- Horizontal counter hcnt (10b):
  - On an hsync edge, line_len <= hcnt+1 (saturating at 1023), then hcnt <= 0.
  - Otherwise hcnt increments, saturating at 1023 with no wrap.
  - The first hsync edge after reset or SEARCH entry only starts counting; it does not update line_len.
- Column:
  - pixel_valid = sampled blank_n.
  - x = count of valid samples since the last hsync edge. The first valid pixel is x=0.
  - x saturates at 1023.
- Row:
  - A line is active if it contained at least one valid sample.
  - On an hsync edge following an active line, the active-line counter increments.
  - On a vsync edge, y resets to 0 and the line counter resets.
  - y saturates at 1023.
- Frame measurement:
  - vcnt counts hsync edges since the last vsync edge.
  - On a vsync edge, frame_lines <= vcnt (saturating), then vcnt <= 0.
- A frame is good when all of the following hold:
  - frame_lines == V_TOTAL.
  - Every line_len in the frame == H_TOTAL.
  - Every active line had exactly H_ACTIVE valid samples.
  - Exactly V_ACTIVE active lines occurred.
  - The frame ends with a vsync edge.
- FSM:
  - SEARCH: locked=0. The first vsync edge moves to CHECK with good=0.
  - CHECK: on each vsync edge, a good frame increments good; a bad frame clears good.
  - CHECK -> LOCKED when good reaches LOCK_FRAMES, with locked=1 from the same edge.
  - LOCKED: any bad line_len or bad active-pixel count is detected at its hsync edge.
  - LOCKED: any bad frame_lines or active-line count is detected at its vsync edge.
  - On detection, timing_error pulses for 1 cycle, locked <= 0 and the FSM goes to SEARCH.
  - SEARCH re-entry clears all accumulated frame errors.
- Simultaneous hsync and vsync edges:
  - The line close is processed first.
  - The frame then sees the incremented vcnt.
  - line_start and frame_start both pulse.
- Stuck sync (no edges): counters saturate, no lock is acquired, and a LOCKED FSM loses lock at the next edge.
- Reset mid-frame: the FSM re-enters SEARCH, and no lock is possible before LOCK_FRAMES complete frames.

Test Plan:
1. Nominal 640x480@60 stimulus (800/525, active-low sync) -> line_len=800 and frame_lines=525. locked rises at the 3rd vsync edge (1 SEARCH edge + 2 good frames). First active pixel gives x=0,y=0; last gives x=639,y=479.
2. While locked, shorten one line to 799 clocks -> at that line's closing hsync edge line_len=799, timing_error pulses 1 cycle, locked=0. Relock after 3 further vsync edges.
3. Frame with 524 lines while locked -> timing_error at the vsync edge, frame_lines=524, locked=0.
4. Hold hsync_in deasserted for 2000 clocks -> the internal counter saturates and, at the next hsync edge, line_len=1023 and no lock is reported.
5. Assert reset_n=0 mid-line at y=200 -> all outputs 0 immediately. After release, locked=0 until 3 vsync edges of good timing.
6. SYNC_POL=1 with inverted syncs, and hsync/vsync leading edges in the same cycle -> line_start and frame_start pulse together and measurements match case 1.
